// File: rtl/tm1638_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_bcd_display
// Purpose  : Latches a 4-digit packed BCD value and writes one complete
//            TM1638 refresh frame (mode, address + 16 data, display control).
// Revision : 1.0
// ============================================================================
module tm1638_bcd_display #(
    parameter int         CLK_DIV    = 4,
    parameter logic [2:0] BRIGHTNESS = 3'd7,
    parameter logic       BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] BCD,
    input  logic        update,
    output logic        busy,
    output logic        done,
    output logic        stb,
    output logic        tm_clk,
    output logic        dio
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    localparam logic [1:0] c_T1 = 2'd0;
    localparam logic [1:0] c_T2 = 2'd1;
    localparam logic [1:0] c_T3 = 2'd2;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [1:0]       r_txn;
    logic [DIV_W-1:0] r_div;
    logic             r_half;
    logic [2:0]       r_bit;
    logic [4:0]       r_byte;
    logic [15:0]      r_digits;
    logic             r_done;

    logic             w_div_last;
    logic             w_half_end;
    logic [4:0]       w_last_byte;
    logic             w_shift_end;
    logic [3:0]       w_addr;
    logic [7:0]       w_tx_byte;
    logic [3:0]       w_blank;
    logic [7:0]       w_code [4];

    assign w_div_last  = (r_div == c_DIV_LAST);
    assign w_half_end  = w_div_last & r_half;
    assign w_last_byte = (r_txn == c_T2) ? 5'd16 : 5'd0;
    assign w_shift_end = w_half_end & (r_bit == 3'd7) & (r_byte == w_last_byte);

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h40;
        endcase
        return s;
    endfunction

    // Blanking propagates right from the thousands digit until a nonzero
    // (or invalid) nibble; the units digit always shows.
    assign w_blank[0] = BLANK_LZ & (r_digits[15:12] == 4'd0);
    assign w_blank[1] = w_blank[0] & (r_digits[11:8] == 4'd0);
    assign w_blank[2] = w_blank[1] & (r_digits[7:4] == 4'd0);
    assign w_blank[3] = 1'b0;

    for (genvar k = 0; k < 4; k++) begin : g_digit
        assign w_code[k] = w_blank[k] ? 8'h00 : seg7(r_digits[15-4*k -: 4]);
    end

    // Byte 0 of T2 is the address command; bytes 1..16 map to addresses 0..15.
    always_comb begin
        w_addr    = r_byte[3:0] - 4'd1;
        w_tx_byte = 8'h00;
        case (r_txn)
            c_T1: w_tx_byte = 8'h40;
            c_T2: begin
                if (r_byte == 5'd0)
                    w_tx_byte = 8'hC0;
                else if (w_addr[3] && !w_addr[0])
                    w_tx_byte = w_code[w_addr[2:1]];
            end
            c_T3:    w_tx_byte = {5'b10001, BRIGHTNESS};
            default: w_tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (update)      w_state_next = c_SETUP;
            c_SETUP: if (w_div_last)  w_state_next = c_SHIFT;
            c_SHIFT: if (w_shift_end) w_state_next = c_HOLD;
            c_HOLD:  if (w_div_last)  w_state_next = (r_txn == c_T3) ? c_IDLE : c_GAP;
            c_GAP:   if (w_half_end)  w_state_next = c_SETUP;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txn    <= c_T1;
            r_div    <= '0;
            r_half   <= 1'b0;
            r_bit    <= 3'd0;
            r_byte   <= 5'd0;
            r_digits <= 16'h0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == c_HOLD) && w_div_last && (r_txn == c_T3);
            if (r_state == c_IDLE) begin
                r_div  <= '0;
                r_half <= 1'b0;
                r_bit  <= 3'd0;
                r_byte <= 5'd0;
                if (update) begin
                    r_txn    <= c_T1;
                    r_digits <= BCD;
                end
            end else begin
                r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
                // r_half selects the low/high half of a bit, or of the gap
                if (w_div_last && (r_state == c_SHIFT || r_state == c_GAP))
                    r_half <= ~r_half;
                if (r_state == c_SHIFT && w_half_end) begin
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        r_byte <= (r_byte == w_last_byte) ? 5'd0 : r_byte + 5'd1;
                end
                if (r_state == c_GAP && w_half_end)
                    r_txn <= r_txn + 2'd1;
            end
        end
    end

    always_comb begin
        busy   = (r_state != c_IDLE);
        done   = r_done;
        stb    = 1'b1;
        tm_clk = 1'b1;
        dio    = 1'b1;
        case (r_state)
            c_SETUP, c_HOLD: stb = 1'b0;
            c_SHIFT: begin
                stb    = 1'b0;
                tm_clk = r_half;
                dio    = w_tx_byte[r_bit];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/tm1638_bcd_display.md
# tm1638_bcd_display

Downstream consumer of the binary-to-BCD converter's 16-bit, 4-digit packed BCD value. On each accepted update request, the block:
- latches the value and converts each digit to a 7-segment code;
- serially writes a complete refresh frame to the TM1638 display/LED controller over its STB/CLK/DIO three-wire bus.

The block is write-only: no key scan and no DIO read-back.

## Interface
Parameters:
- CLK_DIV, 4: TM1638 serial clock half-period in clk cycles; legal range is ≥1.
- BRIGHTNESS, 3'd7: pulse-width setting placed in the display-control command; legal range 0..7.
- BLANK_LZ, 1: 1 blanks leading zero digits (the units digit is never blanked); 0 shows all four digits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- BCD  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- update  in  1  refresh request; sampled only while idle.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- stb  out  1  TM1638 STB, active low.
- tm_clk  out  1  TM1638 CLK; idles high.
- dio  out  1  TM1638 DIO, driven output only.

## Operation
- Reset values (applied asynchronously): stb=1, tm_clk=1, dio=1, busy=0, done=0; FSM=IDLE, all counters 0.
- IDLE: update=1 accepts a request. On acceptance, BCD is latched into a digit register and the FSM enters T1.
  - update while busy is ignored, not queued.
  - BCD changes during a frame have no effect on that frame.
- Frame structure, three transactions, bytes sent LSB first:
  - T1: 0x40 (data write, auto-increment).
  - T2: 0xC0 (address 0), then 16 data bytes for addresses 0x0..0xF.
  - T3: 0x88 | BRIGHTNESS (display on).
- Data bytes:
  - Odd addresses (LED bytes) = 0x00.
  - Address 2k, k=0..3 = 0x00 (blank).
  - Address 8 = thousands, 10 = hundreds, 12 = tens, 14 = units.
- Segment code (bit0=a … bit6=g, bit7=dp=0): 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Nibble >9 → 0x40 (dash).
- Leading-zero blanking (BLANK_LZ=1):
  - Digits left of the first nonzero digit, among thousands/hundreds/tens, emit 0x00.
  - Zeros right of a nonzero digit are shown; an invalid nibble counts as nonzero.
- Per-transaction sub-phases:
  - SETUP: stb low.
  - SHIFT: bits.
  - HOLD: stb still low after the last bit.
  - GAP: stb high. Present after T1 and T2 only.
- Counters: divider 0..CLK_DIV-1, bit 0..7, byte 0..16.

## Timing
- D = CLK_DIV.
- Bit period = 2D cycles:
  - tm_clk falls, and dio takes the new bit in that same cycle;
  - tm_clk stays low D cycles, then high D cycles;
  - dio stays stable across the rising edge.
- Transaction of N bytes:
  - stb low for D (SETUP) + 16D·N + D (HOLD) cycles;
  - tm_clk=1 and dio=1 during SETUP, HOLD and GAP.
- GAP = 2D cycles of stb high.
- Frame lengths: T1 + GAP = 20D, T2 + GAP = 276D, T3 = 18D; total 314D.
- Cycle-level handshake, with update accepted at cycle t:
  - busy=1 for cycles t+1 … t+314D;
  - at cycle t+314D+1: busy=0, done=1 for one cycle, FSM in IDLE;
  - a new update is accepted in that same cycle.
- Reset asserted mid-frame:
  - outputs go to reset values immediately;
  - the partial frame is abandoned and no done pulse is issued;
  - the next accepted update restarts at T1.
- update held high continuously: frames repeat back-to-back, with one IDLE cycle between them.

## Test plan
- Reset: assert rst mid-idle and mid-shift -> stb=tm_clk=dio=1 and busy=done=0 in the same cycle, with no clk edge needed.
- Basic frame: CLK_DIV=2, BCD=0x1234, one-cycle update -> bytes sampled on tm_clk rising edges are:
  - 40; C0, 00×8, 06 00 5B 00 4F 00 66 00; 8F;
  - stb low windows of 36, 548 and 36 cycles, separated by 4-cycle gaps;
  - busy exactly 628 cycles, then a single done pulse.
- Blanking: BCD=0x0007 -> digit bytes 00 00 00 07; BCD=0x0000 -> 00 00 00 3F; BCD=0x1005 -> 06 3F 3F 6D; with BLANK_LZ=0, BCD=0x0007 -> 3F 3F 3F 07.
- Invalid BCD: BCD=0x12A4 -> digit bytes 06 5B 40 66; BRIGHTNESS=3 -> control byte 0x8B.
- Request handling:
  - update re-pulsed and BCD changed to 0x9999 mid-frame -> frame content stays 0x1234 and there is no extra frame;
  - update held high -> next frame starts 1 cycle after done.
- Reset mid-T2 (during the 5th data byte) -> bus idles immediately and done never pulses; a subsequent update yields a complete, correct 40/C0…/8F frame.
